// File: rtl/brq_dmem_pkg.sv
// Shared types and helpers for the brq data-memory responder: load/store
// size encodings, the sweep FSM states, and the byte-lane / load-format
// helpers used by the top level.
package brq_dmem_pkg;

    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } ls_funct_e;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dmem_state_e;

    localparam int unsigned LANES = 4;

    // True when the access is an unknown size or is not naturally aligned.
    function automatic logic access_bad(input logic [2:0] funct3, input logic [1:0] off);
        logic bad;
        case (funct3)
            LS_B, LS_BU: bad = 1'b0;
            LS_H, LS_HU: bad = off[0];
            LS_W:        bad = (off != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte lanes touched by an access of the given size at the given offset.
    function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
        logic [3:0] mask;
        case (funct3)
            LS_B, LS_BU: mask = 4'b0001 << off;
            LS_H, LS_HU: mask = off[1] ? 4'b1100 : 4'b0011;
            default:     mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // Store data arrives right-aligned; copy it onto every lane so the
    // lane mask alone decides which bytes land in memory.
    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] data);
        logic [31:0] rep;
        case (funct3)
            LS_B, LS_BU: rep = {4{data[7:0]}};
            LS_H, LS_HU: rep = {2{data[15:0]}};
            default:     rep = data;
        endcase
        return rep;
    endfunction

    // Pick the addressed byte/half out of a word and extend it to 32 bits.
    function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [2:0] funct3,
                                             input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            LS_B:    res = {{24{b[7]}}, b};
            LS_BU:   res = {24'b0, b};
            LS_H:    res = {{16{h[15]}}, h};
            LS_HU:   res = {16'b0, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/brq_dmem_if.sv
// Core-side data port of the brq data memory. The master modport is the
// core's LDST stage, the slave modport is the memory responder.
// mmio_out only exists when BRQ_DMEM_MMIO_EN is defined.
interface brq_dmem_if #(
    parameter int AddrWidth = 15,
    parameter int DataWidth = 32
);
    logic [AddrWidth-1:0] Data_mem_address;
    logic                 Data_mem_read_en;
    logic                 Data_mem_write_en;
    logic [2:0]           ldst_byte_en;
    logic [DataWidth-1:0] Data_mem_dataIn;
    logic [DataWidth-1:0] Data_mem_dataOut;
    logic                 dmem_ready;
    logic                 dmem_err;
`ifdef BRQ_DMEM_MMIO_EN
    logic [DataWidth-1:0] mmio_out;
`endif

    modport master (
        output Data_mem_address, Data_mem_read_en, Data_mem_write_en,
        output ldst_byte_en, Data_mem_dataIn,
        input  Data_mem_dataOut, dmem_ready, dmem_err
`ifdef BRQ_DMEM_MMIO_EN
        , input mmio_out
`endif
    );

    modport slave (
        input  Data_mem_address, Data_mem_read_en, Data_mem_write_en,
        input  ldst_byte_en, Data_mem_dataIn,
        output Data_mem_dataOut, dmem_ready, dmem_err
`ifdef BRQ_DMEM_MMIO_EN
        , output mmio_out
`endif
    );

endinterface

// File: rtl/brq_dmem_sram.sv
// Single-port synchronous RAM with per-byte write enables. A read that
// coincides with a write to the same word returns the freshly written bytes.
// Contents are never reset; the responder sweeps them clear instead.
module brq_dmem_sram #(
    parameter int AddrBits  = 13,
    parameter int DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [DataWidth/8-1:0] be_i,
    input  logic [AddrBits-1:0]    addr_i,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic                   re_i,
    output logic [DataWidth-1:0]   rdata_o
);
    localparam int Depth = 2 ** AddrBits;
    localparam int Lanes = DataWidth / 8;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] rdata_q;
    logic [DataWidth-1:0] merged;

    // Word as it will look after this edge's write, for write-first reads.
    always_comb begin
        merged = mem_q[addr_i];
        for (int i = 0; i < Lanes; i++) begin
            if (we_i && be_i[i]) begin
                merged[8*i +: 8] = wdata_i[8*i +: 8];
            end
        end
    end

    // Byte-masked write and registered read on the same edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < Lanes; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= merged;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/brq_dmem_responder.sv
// Data-memory slave for the brq core's LDST stage. After reset it sweeps
// every word to zero (unless ClearOnReset is 0), then serves byte/half/word
// stores and formatted loads with one cycle of load latency. Misaligned,
// unknown-size and simultaneous read+write requests raise a one-cycle
// dmem_err. Defining BRQ_DMEM_MMIO_EN maps the word at MmioAddr onto the
// mmio_out register instead of the array.
module brq_dmem_responder
    import brq_dmem_pkg::*;
#(
    parameter int          DataWidth    = 32,
    parameter int          AddrWidth    = 15,
    parameter int          ClearOnReset = 1,
    parameter int unsigned MmioAddr     = 32'h7FFC
) (
    input  logic        brq_clk,
    input  logic        brq_rst,
    brq_dmem_if.slave   bus
);
    localparam int WordBits = AddrWidth - 2;
    localparam logic [WordBits-1:0] LastWord = {WordBits{1'b1}};

    dmem_state_e          state_q;
    logic [WordBits-1:0]  cnt_q;
    logic                 ready_q;
    logic                 err_q;
    logic                 ldZero_q;
    logic [2:0]           ldFunct_q;
    logic [1:0]           ldOff_q;

    logic                 run;
    logic [2:0]           funct3;
    logic [1:0]           off;
    logic [WordBits-1:0]  wordIdx;
    logic                 bad;
    logic                 isMmio;
    logic                 stDo;
    logic                 ldDo;
    logic                 err_d;
    logic [3:0]           mask;
    logic [31:0]          stData;
    logic [DataWidth-1:0] loadWord;

    logic                 sramWe;
    logic                 sramRe;
    logic [3:0]           sramBe;
    logic [WordBits-1:0]  sramAddr;
    logic [DataWidth-1:0] sramWdata;
    logic [DataWidth-1:0] sramRdata;

    assign run     = (state_q == RUN);
    assign funct3  = bus.ldst_byte_en;
    assign off     = bus.Data_mem_address[1:0];
    assign wordIdx = bus.Data_mem_address[AddrWidth-1:2];
    assign bad     = access_bad(funct3, off);
    assign mask    = lane_mask(funct3, off);
    assign stData  = store_data(funct3, bus.Data_mem_dataIn);

`ifdef BRQ_DMEM_MMIO_EN
    localparam logic [AddrWidth-1:0] MmioByte = AddrWidth'(MmioAddr);
    assign isMmio = (wordIdx == MmioByte[AddrWidth-1:2]);
`else
    assign isMmio = 1'b0;
`endif

    // A store still happens alongside a colliding load; the load is dropped.
    assign stDo  = run && bus.Data_mem_write_en && !bad;
    assign ldDo  = run && bus.Data_mem_read_en && !bus.Data_mem_write_en;
    assign err_d = run && (((bus.Data_mem_read_en || bus.Data_mem_write_en) && bad) ||
                           (bus.Data_mem_read_en && bus.Data_mem_write_en));

    // The sweep owns the RAM port during INIT; requests own it in RUN.
    always_comb begin
        sramWe    = 1'b0;
        sramRe    = 1'b0;
        sramBe    = 4'b1111;
        sramAddr  = wordIdx;
        sramWdata = stData;
        if (!run) begin
            sramWe    = 1'b1;
            sramAddr  = cnt_q;
            sramWdata = '0;
        end else begin
            sramWe = stDo && !isMmio;
            sramRe = ldDo && !bad && !isMmio;
            sramBe = mask;
        end
    end

    brq_dmem_sram #(
        .AddrBits  (WordBits),
        .DataWidth (DataWidth)
    ) u_sram (
        .clk_i   (brq_clk),
        .we_i    (sramWe),
        .be_i    (sramBe),
        .addr_i  (sramAddr),
        .wdata_i (sramWdata),
        .re_i    (sramRe),
        .rdata_o (sramRdata)
    );

    // Sweep FSM plus the registered error pulse and load-format controls.
    always_ff @(posedge brq_clk or posedge brq_rst) begin
        if (brq_rst) begin
            state_q   <= (ClearOnReset != 0) ? INIT : RUN;
            cnt_q     <= '0;
            ready_q   <= (ClearOnReset == 0);
            err_q     <= 1'b0;
            ldZero_q  <= 1'b1;
            ldFunct_q <= LS_W;
            ldOff_q   <= 2'b00;
        end else begin
            err_q <= err_d;
            if (state_q == INIT) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == LastWord) begin
                    state_q <= RUN;
                    ready_q <= 1'b1;
                end
            end else if (ldDo) begin
                ldZero_q  <= bad;
                ldFunct_q <= funct3;
                ldOff_q   <= off;
            end
        end
    end

`ifdef BRQ_DMEM_MMIO_EN
    logic [DataWidth-1:0] mmio_q;
    logic [DataWidth-1:0] mmioSnap_q;
    logic                 ldMmio_q;

    // MMIO register takes masked stores; loads capture it so dataOut holds.
    always_ff @(posedge brq_clk or posedge brq_rst) begin
        if (brq_rst) begin
            mmio_q     <= '0;
            mmioSnap_q <= '0;
            ldMmio_q   <= 1'b0;
        end else begin
            if (stDo && isMmio) begin
                for (int i = 0; i < LANES; i++) begin
                    if (mask[i]) begin
                        mmio_q[8*i +: 8] <= stData[8*i +: 8];
                    end
                end
            end
            if (ldDo) begin
                ldMmio_q   <= isMmio;
                mmioSnap_q <= mmio_q;
            end
        end
    end

    assign loadWord     = ldMmio_q ? mmioSnap_q : sramRdata;
    assign bus.mmio_out = mmio_q;
`else
    assign loadWord = sramRdata;
`endif

    assign bus.Data_mem_dataOut = ldZero_q ? '0 : load_fmt(loadWord, ldFunct_q, ldOff_q);
    assign bus.dmem_ready       = ready_q;
    assign bus.dmem_err         = err_q;

endmodule
